// File: rtl/mips_pkg.sv
// Shared MIPS opcode, funct and ALU-op constants plus the ID/EX bundle types.
// Used by id_decode, id_ex_stage and the ALU.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_SLT  = 6'b101010;

  typedef enum logic [1:0] {
    ALU_MEM = 2'b00,
    ALU_BR  = 2'b01,
    ALU_R   = 2'b10,
    ALU_I   = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [5:0]  funct;
    alu_op_e     alu_op;
    logic        alu_src;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        reads_rt;
    logic        illegal;
  } dec_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  funct;
    logic [4:0]  sa;
    alu_op_e     alu_op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic        alu_src;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        illegal;
  } id_ex_t;

  function automatic logic funct_ok(input logic [5:0] f);
    logic ok;
    ok = 1'b0;
    case (f)
      F_SLL, F_SRL, F_SRA, F_SRLV, F_SRAV,
      F_ADDU, F_SUBU, F_AND, F_OR, F_XOR,
      F_SLT:   ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational MIPS decoder: instruction word to EX control bundle.
// Unsupported opcode/funct raises illegal with all side-effect controls off.
module id_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] w_op;
  logic [5:0] w_fn;

  assign w_op = instr[31:26];
  assign w_fn = instr[5:0];

  // opcode/funct decode; defaults describe an illegal instruction
  always_comb begin
    dec          = '0;
    dec.funct    = w_fn;
    dec.alu_op   = ALU_MEM;
    dec.dest     = instr[20:16];
    dec.illegal  = 1'b1;
    unique case (w_op)
      OP_RTYPE: begin
        dec.dest     = instr[15:11];
        dec.reads_rt = 1'b1;
        if (funct_ok(w_fn)) begin
          dec.alu_op    = ALU_R;
          dec.reg_write = 1'b1;
          dec.illegal   = 1'b0;
        end
      end
      OP_LW: begin
        dec.funct     = F_ADDU;
        dec.alu_src   = 1'b1;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.illegal   = 1'b0;
      end
      OP_SW: begin
        dec.funct     = F_ADDU;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.reads_rt  = 1'b1;
        dec.illegal   = 1'b0;
      end
      OP_BEQ: begin
        dec.funct    = F_SUBU;
        dec.alu_op   = ALU_BR;
        dec.branch   = 1'b1;
        dec.reads_rt = 1'b1;
        dec.illegal  = 1'b0;
      end
      OP_ADDIU: begin
        dec.funct     = F_ADDU;
        dec.alu_op    = ALU_I;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.illegal   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// ID_EX_ILLEGAL_TRAP_EN: illegal instructions become a bubble flagged ex_illegal.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] instr,
  input  logic [31:0] read_rs,
  input  logic [31:0] read_rt,
  input  logic        flush,
  output logic        stall_req,
  output logic        ex_valid,
  output logic [5:0]  ex_funct,
  output logic [4:0]  ex_sa,
  output logic [1:0]  ex_alu_op,
  output logic [31:0] ex_read_rs,
  output logic [31:0] ex_read_rt,
  output logic [31:0] ex_imm,
  output logic        ex_alu_src,
  output logic [4:0]  ex_dest,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_illegal
);

  dec_t   w_dec;
  id_ex_t w_load;
  id_ex_t w_next;
  id_ex_t r_ex;
  logic   w_rs_hit;
  logic   w_rt_hit;

  id_decode u_dec (
    .instr (instr),
    .dec   (w_dec)
  );

  assign w_rs_hit = (r_ex.dest == instr[25:21]);
  assign w_rt_hit = (r_ex.dest == instr[20:16]) & w_dec.reads_rt;

  assign stall_req = r_ex.valid & r_ex.mem_read
                   & (r_ex.dest != 5'd0) & id_valid
                   & (w_rs_hit | w_rt_hit);

  // full EX contents for the instruction in ID
  always_comb begin
    w_load           = '0;
    w_load.valid     = 1'b1;
    w_load.funct     = w_dec.funct;
    w_load.sa        = instr[10:6];
    w_load.alu_op    = w_dec.alu_op;
    w_load.rs        = read_rs;
    w_load.rt        = read_rt;
    w_load.imm       = {{16{instr[15]}}, instr[15:0]};
    w_load.alu_src   = w_dec.alu_src;
    w_load.dest      = w_dec.dest;
    w_load.reg_write = w_dec.reg_write;
    w_load.mem_read  = w_dec.mem_read;
    w_load.mem_write = w_dec.mem_write;
    w_load.branch    = w_dec.branch;
  end

  // next EX state: flush, stall and empty ID all insert a bubble
  always_comb begin
    w_next = '0;
    if (flush || stall_req || !id_valid) begin
      w_next = '0;
    end else if (w_dec.illegal) begin
`ifdef ID_EX_ILLEGAL_TRAP_EN
      w_next.illegal = 1'b1;
`else
      w_next = w_load;
`endif
    end else begin
      w_next = w_load;
    end
  end

  // ID/EX register, async reset to a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ex <= '0;
    else       r_ex <= w_next;
  end

  assign ex_valid     = r_ex.valid;
  assign ex_funct     = r_ex.funct;
  assign ex_sa        = r_ex.sa;
  assign ex_alu_op    = r_ex.alu_op;
  assign ex_read_rs   = r_ex.rs;
  assign ex_read_rt   = r_ex.rt;
  assign ex_imm       = r_ex.imm;
  assign ex_alu_src   = r_ex.alu_src;
  assign ex_dest      = r_ex.dest;
  assign ex_reg_write = r_ex.reg_write;
  assign ex_mem_read  = r_ex.mem_read;
  assign ex_mem_write = r_ex.mem_write;
  assign ex_branch    = r_ex.branch;
  assign ex_illegal   = r_ex.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver queues expected stall/EX state,
// monitor compares stall mid-cycle and EX contents after the next edge.
module tb_id_ex_stage;

  typedef struct packed {
    logic        v;
    logic [5:0]  f;
    logic [4:0]  sa;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic        src;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        ill;
  } ex_t;

  typedef struct {
    string name;
    logic  stall;
    ex_t   ex;
  } item_t;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [31:0] instr;
  logic [31:0] read_rs;
  logic [31:0] read_rt;
  logic        flush;
  logic        stall_req;
  logic        ex_valid;
  logic [5:0]  ex_funct;
  logic [4:0]  ex_sa;
  logic [1:0]  ex_alu_op;
  logic [31:0] ex_read_rs;
  logic [31:0] ex_read_rt;
  logic [31:0] ex_imm;
  logic        ex_alu_src;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_illegal;

  item_t q[$];
  int    n_cmp;
  int    n_bad;
  ex_t   act;
  ex_t   bub;

  id_ex_stage dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .instr        (instr),
    .read_rs      (read_rs),
    .read_rt      (read_rt),
    .flush        (flush),
    .stall_req    (stall_req),
    .ex_valid     (ex_valid),
    .ex_funct     (ex_funct),
    .ex_sa        (ex_sa),
    .ex_alu_op    (ex_alu_op),
    .ex_read_rs   (ex_read_rs),
    .ex_read_rt   (ex_read_rt),
    .ex_imm       (ex_imm),
    .ex_alu_src   (ex_alu_src),
    .ex_dest      (ex_dest),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_branch    (ex_branch),
    .ex_illegal   (ex_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign act = {ex_valid, ex_funct, ex_sa, ex_alu_op,
                ex_read_rs, ex_read_rt, ex_imm, ex_alu_src,
                ex_dest, ex_reg_write, ex_mem_read,
                ex_mem_write, ex_branch, ex_illegal};

  function automatic ex_t mk(
    input logic v, input logic [5:0] f, input logic [4:0] sa,
    input logic [1:0] op, input logic [31:0] rs,
    input logic [31:0] rt, input logic [31:0] imm,
    input logic src, input logic [4:0] dest, input logic rw,
    input logic mr, input logic mw, input logic br,
    input logic ill);
    ex_t e;
    e = '{v, f, sa, op, rs, rt, imm, src, dest,
          rw, mr, mw, br, ill};
    return e;
  endfunction

  task automatic chk_ex(input string nm, input ex_t a,
                        input ex_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s ex: got %h want %h", nm, a, e);
    end
  endtask

  task automatic chk_bit(input string nm, input logic a,
                         input logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, a, e);
    end
  endtask

  task automatic drive(input string nm, input logic v,
                       input logic [31:0] ins,
                       input logic [31:0] rs,
                       input logic [31:0] rt,
                       input logic fl, input logic st,
                       input ex_t e);
    item_t it;
    @(posedge clk);
    #2;
    id_valid = v;
    instr    = ins;
    read_rs  = rs;
    read_rt  = rt;
    flush    = fl;
    it.name  = nm;
    it.stall = st;
    it.ex    = e;
    q.push_back(it);
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        it = q[0];
        chk_bit({it.name, " stall"}, stall_req, it.stall);
        @(posedge clk);
        #1;
        chk_ex(it.name, act, it.ex);
        void'(q.pop_front());
      end
    end
  end

  localparam logic [31:0] LW4  = 32'h8C24_0000;
  localparam logic [31:0] AD5  = 32'h0082_2821;

  initial begin : driver
    ex_t e_ill;
    n_cmp    = 0;
    n_bad    = 0;
    bub      = '0;
    reset    = 1'b1;
    id_valid = 1'b0;
    instr    = '0;
    read_rs  = '0;
    read_rt  = '0;
    flush    = 1'b0;
    #3;
    chk_ex("reset", act, bub);
    chk_bit("reset stall", stall_req, 1'b0);
    #4;
    reset = 1'b0;

    drive("addu", 1, 32'h0022_1821, 5, 7, 0, 0,
      mk(1, 6'h21, 0, 2'b10, 5, 7, 32'h1821,
         0, 3, 1, 0, 0, 0, 0));
    drive("lw", 1, 32'h8C24_0008, 32'h10, 32'h99, 0, 0,
      mk(1, 6'h21, 0, 2'b00, 32'h10, 32'h99, 8,
         1, 4, 1, 1, 0, 0, 0));
    drive("lu_stall", 1, AD5, 1, 2, 0, 1, bub);
    drive("lu_go", 1, AD5, 32'h11, 32'h22, 0, 0,
      mk(1, 6'h21, 0, 2'b10, 32'h11, 32'h22, 32'h2821,
         0, 5, 1, 0, 0, 0, 0));
    drive("beq", 1, 32'h1022_FFFF, 3, 3, 0, 0,
      mk(1, 6'h23, 5'h1F, 2'b01, 3, 3, 32'hFFFF_FFFF,
         0, 2, 0, 0, 0, 1, 0));
    drive("sw_flush", 1, 32'hAC22_0004, 8, 9, 1, 0, bub);
    drive("sw", 1, 32'hAC22_0004, 8, 9, 0, 0,
      mk(1, 6'h21, 0, 2'b00, 8, 9, 4,
         1, 2, 0, 0, 1, 0, 0));
    drive("idle", 0, 32'h0022_1821, 5, 7, 0, 0, bub);
    drive("addiu", 1, 32'h2406_FFFE, 0, 5, 0, 0,
      mk(1, 6'h21, 5'h1F, 2'b11, 0, 5, 32'hFFFF_FFFE,
         1, 6, 1, 0, 0, 0, 0));
`ifdef ID_EX_ILLEGAL_TRAP_EN
    e_ill = bub;
    e_ill.ill = 1'b1;
`else
    e_ill = mk(1, 6'h34, 5'h08, 2'b00, 1, 2, 32'h1234,
               0, 2, 0, 0, 0, 0, 0);
`endif
    drive("ill_op", 1, 32'hFC22_1234, 1, 2, 0, 0, e_ill);
`ifdef ID_EX_ILLEGAL_TRAP_EN
    e_ill = bub;
    e_ill.ill = 1'b1;
`else
    e_ill = mk(1, 6'h20, 0, 2'b00, 1, 2, 32'h1820,
               0, 3, 0, 0, 0, 0, 0);
`endif
    drive("ill_fn", 1, 32'h0022_1820, 1, 2, 0, 0, e_ill);

    drive("lw_a", 1, LW4, 32'hA1, 32'hA2, 0, 0,
      mk(1, 6'h21, 0, 2'b00, 32'hA1, 32'hA2, 0,
         1, 4, 1, 1, 0, 0, 0));
    drive("lwlw_stall", 1, 32'h8C85_0000, 32'hB1, 32'hB2,
      0, 1, bub);
    drive("lwlw_go", 1, 32'h8C85_0000, 32'hB1, 32'hB2, 0, 0,
      mk(1, 6'h21, 0, 2'b00, 32'hB1, 32'hB2, 0,
         1, 5, 1, 1, 0, 0, 0));
    drive("lwad_stall", 1, 32'h00A0_3821, 32'hC1, 32'hC2,
      0, 1, bub);
    drive("lwad_go", 1, 32'h00A0_3821, 32'hC1, 32'hC2, 0, 0,
      mk(1, 6'h21, 0, 2'b10, 32'hC1, 32'hC2, 32'h3821,
         0, 7, 1, 0, 0, 0, 0));
    drive("lw_d", 1, LW4, 32'hD1, 32'hD2, 0, 0,
      mk(1, 6'h21, 0, 2'b00, 32'hD1, 32'hD2, 0,
         1, 4, 1, 1, 0, 0, 0));
    drive("sw_rt_stall", 1, 32'hAC24_0000, 32'hE1, 32'hE2,
      0, 1, bub);
    drive("sw_rt_go", 1, 32'hAC24_0000, 32'hE1, 32'hE2, 0, 0,
      mk(1, 6'h21, 0, 2'b00, 32'hE1, 32'hE2, 0,
         1, 4, 0, 0, 1, 0, 0));
    drive("lw_f", 1, LW4, 32'hF1, 32'hF2, 0, 0,
      mk(1, 6'h21, 0, 2'b00, 32'hF1, 32'hF2, 0,
         1, 4, 1, 1, 0, 0, 0));
    drive("addiu_rt", 1, 32'h2404_0001, 0, 4, 0, 0,
      mk(1, 6'h21, 0, 2'b11, 0, 4, 1,
         1, 4, 1, 0, 0, 0, 0));
    drive("lw_r0", 1, 32'h8C20_0000, 3, 4, 0, 0,
      mk(1, 6'h21, 0, 2'b00, 3, 4, 0,
         1, 0, 1, 1, 0, 0, 0));
    drive("r0_nostall", 1, 32'h0000_1821, 0, 0, 0, 0,
      mk(1, 6'h21, 0, 2'b10, 0, 0, 32'h1821,
         0, 3, 1, 0, 0, 0, 0));
    drive("lw_g", 1, LW4, 1, 2, 0, 0,
      mk(1, 6'h21, 0, 2'b00, 1, 2, 0,
         1, 4, 1, 1, 0, 0, 0));
    drive("flush_stall", 1, AD5, 1, 2, 1, 1, bub);
    drive("after_flush", 1, AD5, 6, 7, 0, 0,
      mk(1, 6'h21, 0, 2'b10, 6, 7, 32'h2821,
         0, 5, 1, 0, 0, 0, 0));

    repeat (6) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    @(posedge clk);
    #2;
    id_valid = 1'b1;
    flush    = 1'b0;
    instr    = LW4;
    @(posedge clk);
    #2;
    instr = AD5;
    #1;
    chk_bit("pre_reset stall", stall_req, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk_bit("async_reset stall", stall_req, 1'b0);
    chk_ex("async_reset", act, bub);
    #1;
    reset    = 1'b0;
    id_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 id_valid  input  1  ID holds a valid instruction this cycle.
REQ-004 instr  input  32  MIPS instruction word from IF/ID.
REQ-005 read_rs, read_rt  input  32 each  register-file read data for rs and rt.
REQ-006 flush  input  1  kill the registered EX contents (branch taken).
REQ-007 stall_req  output  1  combinational load-use hazard; IF/ID and PC must hold.
REQ-008 ex_valid  output  1  EX slot holds a real instruction.
REQ-009 ex_funct  output  6  ALU operation code, same encoding as the ALU function field.
REQ-010 ex_sa  output  5  shift amount, instr[10:6].
REQ-011 ex_alu_op  output  2  00 mem, 01 branch, 10 R-type, 11 I-type arithmetic.
REQ-012 ex_read_rs, ex_read_rt, ex_imm  output  32 each  registered operands; ex_imm is sign-extended instr[15:0].
REQ-013 ex_alu_src  output  1  1 selects ex_imm as ALU operand B.
REQ-014 ex_dest  output  5  write register: rd for R-type, rt otherwise.
REQ-015 ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  output  1 each  control bits.
REQ-016 ex_illegal  output  1  registered unsupported-opcode flag.

Function
REQ-017 Decode SHALL be combinational on instr; all ex_* outputs SHALL be registered, latency one cycle.
REQ-018 R-type (opcode 000000) SHALL pass funct unchanged for 000000, 000010, 000011, 000110, 000111, 100001, 100011, 100100, 100101, 100110, 101010; ALU op 10, reg_write 1, dest rd.
REQ-019 LW (100011): funct 100001, op 00, alu_src 1, mem_read 1, reg_write 1, dest rt.
REQ-020 SW (101011): funct 100001, op 00, alu_src 1, mem_write 1, reg_write 0.
REQ-021 BEQ (000100): funct 100011, op 01, alu_src 0, branch 1, reg_write 0.
REQ-022 ADDIU (001001): funct 100001, op 11, alu_src 1, reg_write 1, dest rt.
REQ-023 Any other opcode/funct SHALL set illegal, with all write/mem/branch controls 0.
REQ-024 stall_req SHALL be 1 when ex_valid & ex_mem_read & ex_dest!=0 & id_valid & (ex_dest==instr[25:21] or (ex_dest==instr[20:16] and the instruction reads rt)).
REQ-025 While stall_req=1, next EX state SHALL be a bubble: ex_valid 0, all control bits 0, ex_funct 000000.
REQ-026 The load-use stall SHALL last exactly one cycle per hazard; back-to-back dependent loads each stall once.
REQ-027 flush SHALL override stall and decode: next EX state is a bubble.
REQ-028 id_valid=0 SHALL load a bubble.
REQ-029 Bubble datapath fields (read_rs, read_rt, imm, sa, dest) SHALL be zero.

Reset
REQ-030 Reset SHALL asynchronously force EX state to a bubble: every ex_* output 0.
REQ-031 Reset asserted mid-stall SHALL drop stall_req to 0 in the same cycle (ex_valid=0).

Configuration
REQ-032 Macro ID_EX_ILLEGAL_TRAP_EN defined: illegal instructions SHALL load a bubble with ex_illegal=1 (ex_valid=0).
REQ-033 Macro undefined: illegal instructions SHALL load with ex_valid=1, raw funct, controls 0; ex_illegal SHALL be tied 0.

Structure
REQ-034 Opcode, funct and ALU-op constants SHALL live in shared package mips_pkg, used also by the ALU.
REQ-035 Decode SHALL be sub-module id_decode (combinational); id_ex_stage holds the hazard check and ID/EX register.

Verification
REQ-036 ADDU $3,$1,$2 (0x00221821), rs=5, rt=7 -> next cycle ex_funct 100001, ex_alu_op 10, ex_dest 3, reg_write 1.
REQ-037 LW $4,8($1) then ADDU $5,$4,$2 -> stall_req=1 one cycle, bubble in EX, then ADDU loads with ex_valid 1.
REQ-038 BEQ $1,$2,-1 -> ex_imm 0xFFFFFFFF, ex_funct 100011, ex_branch 1, ex_alu_op 01.
REQ-039 flush=1 with valid SW in ID -> next cycle all ex_* 0.
REQ-040 Opcode 111111 with ID_EX_ILLEGAL_TRAP_EN -> ex_illegal 1, ex_valid 0; without -> ex_valid 1, ex_illegal 0, controls 0.
REQ-041 reset pulse during stall -> outputs 0 and stall_req 0 immediately, before next clk edge.
